// File: rtl/cpu_pkg.sv
// Shared widths and the ID/EX payload type for the operand-fetch stage.
package cpu_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned OP_W   = 6;
    localparam int unsigned NREGS  = 1 << ADDR_W;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [ADDR_W-1:0] rd;
        logic              wen;
        logic [OP_W-1:0]   op;
    } idex_t;

endpackage

// File: rtl/opfetch_scoreboard.sv
// Busy-bit scoreboard: one bit per architectural register, with a set port,
// two clear ports (writeback and flush kill) and three lookup ports.
module opfetch_scoreboard
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_idx,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_idx,
    input  logic              kill_en,
    input  logic [ADDR_W-1:0] kill_idx,
    input  logic [ADDR_W-1:0] look_a_idx,
    input  logic [ADDR_W-1:0] look_b_idx,
    input  logic [ADDR_W-1:0] look_d_idx,
    output logic              look_a,
    output logic              look_b,
    output logic              look_d,
    output logic [NREGS-1:0]  busy_vec
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    // Clears first so a same-edge set of the same register wins.
    always_comb begin
        busy_d = busy_q;
        if (clr_en) begin
            busy_d[clr_idx] = 1'b0;
        end
        if (kill_en) begin
            busy_d[kill_idx] = 1'b0;
        end
        if (set_en) begin
            busy_d[set_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign look_a   = busy_q[look_a_idx];
    assign look_b   = busy_q[look_b_idx];
    assign look_d   = busy_q[look_d_idx];
    assign busy_vec = busy_q;

endmodule

// File: rtl/operand_fetch.sv
// Register-read stage: drives regfile read addresses, stalls on scoreboard
// hazards, and captures operands into a one-entry ID/EX register.
// Build option OPFETCH_FWD_EN adds a writeback-to-operand bypass.
module operand_fetch
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_rs1,
    input  logic [ADDR_W-1:0] in_rs2,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic              in_wen,
    input  logic [OP_W-1:0]   in_op,
    input  logic              flush,
    output logic [ADDR_W-1:0] rf_addrA,
    output logic [ADDR_W-1:0] rf_addrB,
    input  logic [DATA_W-1:0] rf_outA,
    input  logic [DATA_W-1:0] rf_outB,
    input  logic              wb_load,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic [ADDR_W-1:0] out_rd,
    output logic              out_wen,
    output logic [OP_W-1:0]   out_op,
    output logic [NREGS-1:0]  busy_vec
);

    logic              busy_a;
    logic              busy_b;
    logic              busy_d;
    logic              hazard;
    logic              space;
    logic              issue;
    logic              kill_en;
    logic [DATA_W-1:0] opnd_a;
    logic [DATA_W-1:0] opnd_b;
    logic              valid_q;
    idex_t             idex_q;
    idex_t             idex_d;

    assign rf_addrA = in_rs1;
    assign rf_addrB = in_rs2;

`ifdef OPFETCH_FWD_EN
    logic byp_a;
    logic byp_b;

    // A source being written back this cycle is taken straight from wb_data.
    assign byp_a  = wb_load & (wb_addr == in_rs1);
    assign byp_b  = wb_load & (wb_addr == in_rs2);
    assign hazard = (busy_a & ~byp_a) | (busy_b & ~byp_b) | (in_wen & busy_d);
    assign opnd_a = byp_a ? wb_data : rf_outA;
    assign opnd_b = byp_b ? wb_data : rf_outB;
`else
    logic wb_data_unused;

    assign wb_data_unused = ^wb_data;
    assign hazard = busy_a | busy_b | (in_wen & busy_d);
    assign opnd_a = rf_outA;
    assign opnd_b = rf_outB;
`endif

    assign space    = ~valid_q | out_ready;
    assign in_ready = ~hazard & space & ~flush;
    assign issue    = in_valid & in_ready;
    assign kill_en  = flush & valid_q & idex_q.wen;

    always_comb begin
        idex_d     = idex_q;
        idex_d.a   = opnd_a;
        idex_d.b   = opnd_b;
        idex_d.rd  = in_rd;
        idex_d.wen = in_wen;
        idex_d.op  = in_op;
    end

    opfetch_scoreboard u_sb (
        .clk        (clk),
        .rst_n      (rst_n),
        .set_en     (issue & in_wen),
        .set_idx    (in_rd),
        .clr_en     (wb_load),
        .clr_idx    (wb_addr),
        .kill_en    (kill_en),
        .kill_idx   (idex_q.rd),
        .look_a_idx (in_rs1),
        .look_b_idx (in_rs2),
        .look_d_idx (in_rd),
        .look_a     (busy_a),
        .look_b     (busy_b),
        .look_d     (busy_d),
        .busy_vec   (busy_vec)
    );

    // ID/EX register: flush kills, issue loads, a bare consume empties.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            idex_q  <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (issue) begin
            valid_q <= 1'b1;
            idex_q  <= idex_d;
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign out_valid = valid_q;
    assign out_a     = idex_q.a;
    assign out_b     = idex_q.b;
    assign out_rd    = idex_q.rd;
    assign out_wen   = idex_q.wen;
    assign out_op    = idex_q.op;

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: regfile model, expected-entry queue
// filled on issue and drained on consume, plus directed stall/flush/reset checks.
module tb_operand_fetch;
    import cpu_pkg::*;

    localparam int unsigned HALF = 15;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_rs1;
    logic [ADDR_W-1:0] in_rs2;
    logic [ADDR_W-1:0] in_rd;
    logic              in_wen;
    logic [OP_W-1:0]   in_op;
    logic              flush;
    logic [ADDR_W-1:0] rf_addrA;
    logic [ADDR_W-1:0] rf_addrB;
    logic [DATA_W-1:0] rf_outA;
    logic [DATA_W-1:0] rf_outB;
    logic              wb_load;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_a;
    logic [DATA_W-1:0] out_b;
    logic [ADDR_W-1:0] out_rd;
    logic              out_wen;
    logic [OP_W-1:0]   out_op;
    logic [NREGS-1:0]  busy_vec;

    int n_chk  = 0;
    int n_pass = 0;

    logic [DATA_W-1:0] rf [NREGS];
    idex_t             exp_q [$];

`ifdef OPFETCH_FWD_EN
    localparam logic FWD = 1'b1;
`else
    localparam logic FWD = 1'b0;
`endif

    operand_fetch dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_rd     (in_rd),
        .in_wen    (in_wen),
        .in_op     (in_op),
        .flush     (flush),
        .rf_addrA  (rf_addrA),
        .rf_addrB  (rf_addrB),
        .rf_outA   (rf_outA),
        .rf_outB   (rf_outB),
        .wb_load   (wb_load),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_rd    (out_rd),
        .out_wen   (out_wen),
        .out_op    (out_op),
        .busy_vec  (busy_vec)
    );

    initial clk = 1'b0;
    always #HALF clk = ~clk;

    // Register file model: write on the rising edge, asynchronous read.
    assign rf_outA = rf[rf_addrA];
    assign rf_outB = rf[rf_addrB];
    always @(posedge clk) if (wb_load) rf[wb_addr] <= wb_data;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int rs1, input int rs2, input int rd, input logic wen, input int op);
        in_valid = 1'b1;
        in_rs1   = ADDR_W'(rs1);
        in_rs2   = ADDR_W'(rs2);
        in_rd    = ADDR_W'(rd);
        in_wen   = wen;
        in_op    = OP_W'(op);
    endtask

    // Scoreboard: push on issue, pop on consume, discard on flush.
    always @(negedge clk) begin : mon
        idex_t e;
        if (rst_n) begin
            if (out_valid && flush) begin
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end else if (out_valid && out_ready) begin
                chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("sb_a", e.a, out_a);
                    chk("sb_b", e.b, out_b);
                    chk("sb_rd", 32'(out_rd), 32'(e.rd));
                    chk("sb_wen", 32'(out_wen), 32'(e.wen));
                    chk("sb_op", 32'(out_op), 32'(e.op));
                end
            end
            if (in_valid && in_ready) begin
                e.a   = (FWD && wb_load && wb_addr == in_rs1) ? wb_data : rf[in_rs1];
                e.b   = (FWD && wb_load && wb_addr == in_rs2) ? wb_data : rf[in_rs2];
                e.rd  = in_rd;
                e.wen = in_wen;
                e.op  = in_op;
                exp_q.push_back(e);
            end
        end
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
        in_wen = 1'b0; in_op = '0; flush = 1'b0; wb_load = 1'b0; wb_addr = '0;
        wb_data = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", busy_vec, 32'd0);
        chk("rst_a", out_a, 32'd0);
        chk("rst_b", out_b, 32'd0);
        chk("rst_rd_wen_op", 32'({out_rd, out_wen, out_op}), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;

        // Preload every register through the write port, then r5 = 0x1234.
        for (int i = 0; i < int'(NREGS); i++) begin
            wb_load = 1'b1; wb_addr = ADDR_W'(i); wb_data = 32'hA500_0000 | 32'(i);
            tick();
        end
        wb_addr = 5'd5; wb_data = 32'h1234;
        tick();
        wb_load = 1'b0;
        out_ready = 1'b1;

        // Basic read of r5 on both ports.
        drive(5, 5, 1, 1'b0, 1);
        #1 chk("t1_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_a", out_a, 32'h1234);
        chk("t1_b", out_b, 32'h1234);
        tick();

        // RAW stall on r7 until writeback (same-cycle bypass when forwarding).
        drive(0, 0, 7, 1'b1, 2);
        tick();
        in_valid = 1'b0;
        chk("t2_busy7", 32'(busy_vec[7]), 32'd1);
        drive(7, 0, 8, 1'b0, 3);
        #1 chk("t2_stall0", 32'(in_ready), 32'd0);
        tick();
        chk("t2_stall1", 32'(in_ready), 32'd0);
        wb_load = 1'b1; wb_addr = 5'd7; wb_data = 32'hCAFE;
        #1 chk("t2_wb_cycle", 32'(in_ready), 32'(FWD));
        tick();
        wb_load = 1'b0;
        if (!FWD) begin
            #1 chk("t2_release", 32'(in_ready), 32'd1);
            tick();
        end
        in_valid = 1'b0;
        chk("t2_valid", 32'(out_valid), 32'd1);
        chk("t2_a", out_a, 32'hCAFE);
        chk("t2_busy7_clr", 32'(busy_vec[7]), 32'd0);
        tick();

        // Backpressure holds the entry and blocks issue.
        out_ready = 1'b0;
        drive(1, 2, 10, 1'b0, 5);
        tick();
        drive(3, 4, 11, 1'b0, 6);
        for (int i = 0; i < 3; i++) begin
            #1 chk("t4_ready", 32'(in_ready), 32'd0);
            chk("t4_a_hold", out_a, 32'hA500_0001);
            chk("t4_b_hold", out_b, 32'hA500_0002);
            chk("t4_op_hold", 32'(out_op), 32'd5);
            tick();
        end
        out_ready = 1'b1;
        #1 chk("t4_release", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("t4_next_a", out_a, 32'hA500_0003);
        tick();

        // Flush of an entry writing r9 clears its busy bit.
        out_ready = 1'b0;
        drive(2, 2, 9, 1'b1, 7);
        tick();
        drive(4, 4, 12, 1'b0, 1);
        chk("t5_busy9", 32'(busy_vec[9]), 32'd1);
        flush = 1'b1;
        #1 chk("t5_no_issue", 32'(in_ready), 32'd0);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("t5_valid", 32'(out_valid), 32'd0);
        chk("t5_busy9_clr", 32'(busy_vec[9]), 32'd0);
        out_ready = 1'b1;

        // Same-edge set and clear of r3: set wins.
        drive(0, 0, 3, 1'b1, 8);
        wb_load = 1'b1; wb_addr = 5'd3; wb_data = 32'h3333;
        tick();
        wb_load = 1'b0;
        in_valid = 1'b0;
        chk("t6_busy3", 32'(busy_vec[3]), 32'd1);
        tick();

        // Async reset while backpressured drops entry and all busy bits.
        out_ready = 1'b0;
        drive(1, 1, 13, 1'b1, 9);
        tick();
        in_valid = 1'b0;
        chk("t6_held", 32'(out_valid), 32'd1);
        chk("t6_busy13", 32'(busy_vec[13]), 32'd1);
        rst_n = 1'b0;
        #2;
        chk("t6_rst_busy", busy_vec, 32'd0);
        chk("t6_rst_valid", 32'(out_valid), 32'd0);
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        tick();

        chk("q_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
